riscv_alu_hs: RTL

Parametrised, handshaked ALU for the RV32I datapath. It is the next generation of the registered ALU: width is configurable, and it adds SLL and correct signed/unsigned SLT. Operands enter through a valid/ready port and results leave through a valid/ready port, so the block can sit between decode and writeback with back-pressure. An optional iterative multiplier (MUL, low half) occupies the unit for XLEN cycles.

---
 rtl/riscv_alu_hs.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/riscv_alu_hs.sv
// Handshaked RV32I-style ALU with a one-entry output register and an optional
// iterative multiplier, enabled by defining RISCVALU_MUL_EN.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | no multiply pending; single-cycle ops accepted when output frees
// S_MUL  | shift-add multiply in progress, one multiplier bit per cycle
module riscv_alu_hs #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      ALUct1,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [XLEN-1:0] ALUout,
    output logic            zero,
    output logic            illegal,
    output logic            out_valid,
    input  logic            out_ready
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t          state;
    logic            accept;
    logic            is_mul;
    logic            single_load;
    logic            mul_done;
    logic [XLEN-1:0] mul_result;
    logic [XLEN-1:0] res;
    logic            res_ill;
    logic [SHW-1:0]  shamt;

    assign in_ready    = (state == S_IDLE) && (!out_valid || out_ready);
    assign accept      = in_valid && in_ready;
    assign single_load = accept && !is_mul;
    assign shamt       = B[SHW-1:0];

    always_comb begin
        res     = '0;
        res_ill = 1'b0;
        case (ALUct1)
            OP_AND:  res = A & B;
            OP_OR:   res = A | B;
            OP_ADD:  res = A + B;
            OP_SUB:  res = A - B;
            OP_XOR:  res = A ^ B;
            OP_NOR:  res = ~(A | B);
            OP_SLL:  res = A << shamt;
            OP_SRL:  res = A >> shamt;
            OP_SRA:  res = $unsigned($signed(A) >>> shamt);
            OP_SLT:  res = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: res = {{(XLEN-1){1'b0}}, (A < B)};
            // OP_MUL lands here too; with the multiplier built it never loads via this path
            default: begin
                res     = '0;
                res_ill = 1'b1;
            end
        endcase
    end

`ifdef RISCVALU_MUL_EN
    state_t          state_nxt;
    logic [SHW-1:0]  cnt;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] acc_nxt;
    logic            mul_start;

    assign is_mul     = (ALUct1 == OP_MUL);
    assign mul_start  = accept && is_mul;
    assign acc_nxt    = acc + (mplier[0] ? mcand : '0);
    assign mul_done   = (state == S_MUL) && (cnt == SHW'(XLEN-1));
    assign mul_result = acc_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (mul_start) state_nxt = S_MUL;
            S_MUL:   if (mul_done)  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else begin
            state <= state_nxt;
            if (mul_start) begin
                mcand  <= A;
                mplier <= B;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == S_MUL) begin
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                acc    <= acc_nxt;
                cnt    <= mul_done ? '0 : cnt + SHW'(1);
            end
        end
    end
`else
    assign state      = S_IDLE;
    assign is_mul     = 1'b0;
    assign mul_done   = 1'b0;
    assign mul_result = '0;
`endif

    // A multiply is only accepted with the output register empty, so mul_done never collides with a held result
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            ALUout    <= '0;
            zero      <= 1'b1;
            illegal   <= 1'b0;
        end else if (single_load) begin
            out_valid <= 1'b1;
            ALUout    <= res;
            zero      <= (res == '0);
            illegal   <= res_ill;
        end else if (mul_done) begin
            out_valid <= 1'b1;
            ALUout    <= mul_result;
            zero      <= (mul_result == '0);
            illegal   <= 1'b0;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
